// File: rtl/fpaddsub_pkg.sv
// Shared definitions for the FP add/sub normalisation datapath.
//  - Default widths for the mantissa sum and the sideband tag.
//  - shift_t: shift-count type at the default sum width.
//  - lzc_sat(): behavioural leading-zero count with saturation. It is the
//    reference used by the lzc self-check and by the testbench model.
package fpaddsub_pkg;

    localparam int unsigned FPADD_SUM_W_DEF   = 17;
    localparam int unsigned FPADD_TAG_W_DEF   = 8;
    localparam int unsigned FPADD_SHIFT_W_DEF = $clog2(FPADD_SUM_W_DEF);

    typedef logic [FPADD_SHIFT_W_DEF-1:0] shift_t;

    // Leading zeros of sum[width-1:0], counted from bit width-1, capped at max_shift.
    function automatic int unsigned lzc_sat(input logic [31:0] sum,
                                            input int unsigned max_shift,
                                            input int unsigned width = FPADD_SUM_W_DEF);
        int unsigned cnt;
        logic        found;
        cnt   = 0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < int'(width) && !found) begin
                if (sum[i]) begin
                    found = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
        return (cnt > max_shift) ? max_shift : cnt;
    endfunction

endpackage

// File: rtl/fpaddsub_lzc.sv
// Combinational saturating leading-zero counter, built as a binary priority tree.
//  sum_i  [SUM_W]    value whose leading zeros (from bit SUM_W-1) are counted
//  lzc_o  [SHIFT_W]  min(leading zeros, MAX_SHIFT); all-zero input gives MAX_SHIFT
// The input is zero-padded at the LSB end up to a power of two so every tree level
// halves cleanly. Padding cannot change a non-zero count, and the all-zero case is
// saturated anyway.
module fpaddsub_lzc
    import fpaddsub_pkg::*;
#(
    parameter  int unsigned SUM_W     = FPADD_SUM_W_DEF,
    parameter  int unsigned MAX_SHIFT = SUM_W - 4,
    localparam int unsigned SHIFT_W   = $clog2(SUM_W)
) (
    input  logic [SUM_W-1:0]   sum_i,
    output logic [SHIFT_W-1:0] lzc_o
);

    localparam int unsigned PAD_W = 1 << SHIFT_W;
    localparam logic [SHIFT_W-1:0] MAX_S = SHIFT_W'(MAX_SHIFT);

    logic [PAD_W-1:0] padded;
    assign padded = PAD_W'(sum_i) << (PAD_W - SUM_W);

    // Level l has PAD_W>>l nodes; node j covers bits from the MSB side. Each node
    // reports whether its span is all zero and, if not, the zero count inside it.
    for (genvar l = 0; l <= SHIFT_W; l++) begin : g_lvl
        localparam int unsigned N = PAD_W >> l;
        logic [SHIFT_W-1:0] cnt  [N];
        logic               zero [N];
        for (genvar j = 0; j < N; j++) begin : g_node
            if (l == 0) begin : g_leaf
                assign zero[j] = ~padded[PAD_W-1-j];
                assign cnt[j]  = '0;
            end else begin : g_merge
                // Left child is the more significant half.
                assign zero[j] = g_lvl[l-1].zero[2*j] & g_lvl[l-1].zero[2*j+1];
                assign cnt[j]  = g_lvl[l-1].zero[2*j]
                               ? (SHIFT_W'(1 << (l - 1)) | g_lvl[l-1].cnt[2*j+1])
                               : g_lvl[l-1].cnt[2*j];
            end
        end
    end

    logic [SHIFT_W-1:0] root_cnt;
    logic               root_zero;
    assign root_cnt  = g_lvl[SHIFT_W].cnt[0];
    assign root_zero = g_lvl[SHIFT_W].zero[0];

    assign lzc_o = (root_zero || (root_cnt > MAX_S)) ? MAX_S : root_cnt;

endmodule

// File: rtl/fpaddsub_norm_pipe.sv
// Two-stage elastic normalisation pipe for the FP add/sub datapath.
// S1 registers the sum, tag and saturated leading-zero count; S2 registers the
// left-shifted mantissa, the shift amount and the tag.
//  clk, rst_n            clock (rising edge), asynchronous active-low reset
//  in_valid/in_ready     input handshake; in_ready depends combinationally on out_ready
//  in_sum [SUM_W]        unnormalised mantissa sum (hidden bit + GRS)
//  in_tag [TAG_W]        sideband, passed through unmodified
//  out_valid/out_ready   output handshake
//  out_mant [SUM_W]      in_sum << out_shift
//  out_shift [SHIFT_W]   normalisation shift amount
//  out_tag [TAG_W]       sideband aligned with the result
//  out_zero              only when FPADD_NORM_ZERO_EN is defined: accepted sum was zero;
//                        out_shift is then forced to 0 so the exponent is left alone
module fpaddsub_norm_pipe
    import fpaddsub_pkg::*;
#(
    parameter  int unsigned SUM_W     = FPADD_SUM_W_DEF,
    parameter  int unsigned MAX_SHIFT = SUM_W - 4,
    parameter  int unsigned TAG_W     = FPADD_TAG_W_DEF,
    localparam int unsigned SHIFT_W   = $clog2(SUM_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SUM_W-1:0]   in_sum,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SUM_W-1:0]   out_mant,
    output logic [SHIFT_W-1:0] out_shift,
    output logic [TAG_W-1:0]   out_tag
`ifdef FPADD_NORM_ZERO_EN
    ,
    output logic               out_zero
`endif
);

    // Stage registers
    logic               s1_valid_q, s1_valid_d;
    logic [SUM_W-1:0]   s1_sum_q,   s1_sum_d;
    logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;
    logic [SHIFT_W-1:0] s1_lzc_q,   s1_lzc_d;

    logic               s2_valid_q, s2_valid_d;
    logic [SUM_W-1:0]   s2_mant_q,  s2_mant_d;
    logic [SHIFT_W-1:0] s2_shift_q, s2_shift_d;
    logic [TAG_W-1:0]   s2_tag_q,   s2_tag_d;
`ifdef FPADD_NORM_ZERO_EN
    logic               s2_zero_q,  s2_zero_d;
    logic               s1_is_zero;
`endif

    logic               s1_adv, s2_adv;
    logic               s1_load, s2_load;
    logic [SHIFT_W-1:0] in_lzc;
    logic [SUM_W-1:0]   shifted;

    fpaddsub_lzc #(
        .SUM_W     (SUM_W),
        .MAX_SHIFT (MAX_SHIFT)
    ) u_lzc (
        .sum_i (in_sum),
        .lzc_o (in_lzc)
    );

    // Handshake: a stage may advance when it is empty or the next one advances.
    always_comb begin
        s2_adv   = ~s2_valid_q | out_ready;
        s1_adv   = ~s1_valid_q | s2_adv;
        in_ready = s1_adv;
        s1_load  = s1_adv & in_valid;
        s2_load  = s2_adv & s1_valid_q;
    end

    // Barrel shifter: level k shifts by 2**k when bit k of the count is set.
    always_comb begin
        shifted = s1_sum_q;
        for (int k = 0; k < int'(SHIFT_W); k++) begin
            if (s1_lzc_q[k]) begin
                shifted = shifted << (1 << k);
            end
        end
    end

`ifdef FPADD_NORM_ZERO_EN
    assign s1_is_zero = (s1_sum_q == '0);
`endif

    // Next-state: data registers only load on an actual transfer so that they hold
    // steady during stalls and while the stage is empty.
    always_comb begin
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_sum_d   = s1_load ? in_sum : s1_sum_q;
        s1_tag_d   = s1_load ? in_tag : s1_tag_q;
        s1_lzc_d   = s1_load ? in_lzc : s1_lzc_q;

        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_mant_d  = s2_load ? shifted : s2_mant_q;
        s2_tag_d   = s2_load ? s1_tag_q : s2_tag_q;
`ifdef FPADD_NORM_ZERO_EN
        s2_zero_d  = s2_load ? s1_is_zero : s2_zero_q;
        s2_shift_d = s2_load ? (s1_is_zero ? '0 : s1_lzc_q) : s2_shift_q;
`else
        s2_shift_d = s2_load ? s1_lzc_q : s2_shift_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_tag_q   <= '0;
            s1_lzc_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_mant_q  <= '0;
            s2_shift_q <= '0;
            s2_tag_q   <= '0;
`ifdef FPADD_NORM_ZERO_EN
            s2_zero_q  <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_tag_q   <= s1_tag_d;
            s1_lzc_q   <= s1_lzc_d;
            s2_valid_q <= s2_valid_d;
            s2_mant_q  <= s2_mant_d;
            s2_shift_q <= s2_shift_d;
            s2_tag_q   <= s2_tag_d;
`ifdef FPADD_NORM_ZERO_EN
            s2_zero_q  <= s2_zero_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign out_mant  = s2_mant_q;
    assign out_shift = s2_shift_q;
    assign out_tag   = s2_tag_q;
`ifdef FPADD_NORM_ZERO_EN
    assign out_zero  = s2_zero_q;
`endif

`ifndef SYNTHESIS
    // Tree counter must agree with the behavioural count for every held S1 entry.
    lzc_matches_ref: assert property (@(posedge clk) disable iff (!rst_n)
        s1_valid_q |-> (32'(s1_lzc_q) == lzc_sat(32'(s1_sum_q), MAX_SHIFT, SUM_W)));
`endif

endmodule

// File: tb/tb_fpaddsub_norm_pipe.sv
module tb_fpaddsub_norm_pipe;
    import fpaddsub_pkg::*;

    localparam int unsigned SUM_W     = 17;
    localparam int unsigned MAX_SHIFT = 13;
    localparam int unsigned TAG_W     = 8;
    localparam int unsigned N_RAND    = 10000;
    localparam int unsigned BUDGET    = 40000;
`ifdef FPADD_NORM_ZERO_EN
    localparam logic [4:0] ZERO_SHIFT = 5'd0;
`else
    localparam logic [4:0] ZERO_SHIFT = 5'd13;
`endif

    logic             clk, rst_n;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [SUM_W-1:0] in_sum, out_mant;
    logic [TAG_W-1:0] in_tag, out_tag;
    shift_t           out_shift;
`ifdef FPADD_NORM_ZERO_EN
    logic             out_zero;
`endif

    int errors;
    int checks;

    typedef struct {
        logic [SUM_W-1:0] sum;
        logic [TAG_W-1:0] tag;
    } item_t;
    item_t exp_q[$];

    fpaddsub_norm_pipe #(
        .SUM_W     (SUM_W),
        .MAX_SHIFT (MAX_SHIFT),
        .TAG_W     (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_shift (out_shift),
        .out_tag   (out_tag)
`ifdef FPADD_NORM_ZERO_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: position of the top set bit via log2, then saturate.
    function automatic logic [4:0] model_shift(input logic [SUM_W-1:0] s);
        int lz;
        if (s == '0) return ZERO_SHIFT;
        lz = int'(SUM_W) - $clog2(int'(s) + 1);
        if (lz > int'(MAX_SHIFT)) lz = int'(MAX_SHIFT);
        return 5'(lz);
    endfunction

    function automatic logic [SUM_W-1:0] model_mant(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] m;
        m = s << model_shift(s);
        return m;
    endfunction

    task automatic push_single(input logic [SUM_W-1:0] s, input logic [TAG_W-1:0] t);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_sum   = s;
        in_tag   = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sum   = 17'($urandom);
        in_tag   = 8'($urandom);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_mant !== '0) begin errors++;
            $display("FAIL reset_mant: got %h want 0", out_mant); end
        checks++; if (out_shift !== '0) begin errors++;
            $display("FAIL reset_shift: got %0d want 0", out_shift); end
        checks++; if (out_tag !== '0) begin errors++;
            $display("FAIL reset_tag: got %h want 0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef FPADD_NORM_ZERO_EN
        checks++; if (out_zero !== 1'b0) begin errors++;
            $display("FAIL reset_zero: got %b want 0", out_zero); end
`endif
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL post_reset_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_normalise();
        logic [SUM_W-1:0] sums   [3];
        logic [4:0]       shifts [3];
        logic [TAG_W-1:0] tag;
        sums   = '{17'h10000, 17'h00100, 17'h00010};
        shifts = '{5'd0, 5'd8, 5'd12};
        for (int i = 0; i < 3; i++) begin
            tag = 8'(8'h30 + i);
            push_single(sums[i], tag);
            checks++; if (out_valid !== 1'b0) begin errors++;
                $display("FAIL norm_latency[%0d]: out_valid %b want 0 one cycle in", i, out_valid);
            end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++;
                $display("FAIL norm_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_mant !== 17'h10000) begin errors++;
                $display("FAIL norm_mant[%0d]: got %h want 10000", i, out_mant); end
            checks++; if (out_shift !== shifts[i]) begin errors++;
                $display("FAIL norm_shift[%0d]: got %0d want %0d", i, out_shift, shifts[i]); end
            checks++; if (out_tag !== tag) begin errors++;
                $display("FAIL norm_tag[%0d]: got %h want %h", i, out_tag, tag); end
        end
    endtask

    task automatic test_saturation();
        logic [SUM_W-1:0] sums   [2];
        logic [SUM_W-1:0] mants  [2];
        logic [4:0]       shifts [2];
        logic [TAG_W-1:0] tag;
        sums   = '{17'h00001, 17'h00000};
        mants  = '{17'h02000, 17'h00000};
        shifts = '{5'd13, ZERO_SHIFT};
        for (int i = 0; i < 2; i++) begin
            tag = 8'(8'hC0 + i);
            push_single(sums[i], tag);
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++;
                $display("FAIL sat_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_mant !== mants[i]) begin errors++;
                $display("FAIL sat_mant[%0d]: got %h want %h", i, out_mant, mants[i]); end
            checks++; if (out_shift !== shifts[i]) begin errors++;
                $display("FAIL sat_shift[%0d]: got %0d want %0d", i, out_shift, shifts[i]); end
            checks++; if (out_tag !== tag) begin errors++;
                $display("FAIL sat_tag[%0d]: got %h want %h", i, out_tag, tag); end
`ifdef FPADD_NORM_ZERO_EN
            checks++; if (out_zero !== (i == 1)) begin errors++;
                $display("FAIL sat_zero[%0d]: got %b want %b", i, out_zero, (i == 1)); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int               sent, recv;
        logic             prev_stall;
        logic [SUM_W-1:0] prev_mant;
        logic [TAG_W-1:0] prev_tag;
        item_t            it, e;
        sent = 0; recv = 0; prev_stall = 1'b0;
        prev_mant = '0; prev_tag = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 6 && cyc <= 10);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_sum   = 17'h1FFFF >> (sent * 2);
                in_tag   = 8'(8'h50 + sent);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 6 && cyc <= 10) begin
                checks++; if (in_ready !== 1'b0) begin errors++;
                    $display("FAIL b2b_in_ready[%0d]: got %b want 0", cyc, in_ready); end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_mant !== prev_mant || out_tag !== prev_tag) begin
                    errors++;
                    $display("FAIL b2b_hold[%0d]: got v=%b m=%h t=%h want v=1 m=%h t=%h",
                             cyc, out_valid, out_mant, out_tag, prev_mant, prev_tag);
                end
            end
            if (in_valid && in_ready) begin
                it.sum = in_sum; it.tag = in_tag;
                exp_q.push_back(it);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got tag %h want no output", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if (out_tag !== e.tag || out_mant !== model_mant(e.sum) ||
                        out_shift !== model_shift(e.sum)) begin
                        errors++;
                        $display("FAIL b2b_item[%0d]: got t=%h m=%h s=%0d want t=%h m=%h s=%0d",
                                 recv, out_tag, out_mant, out_shift, e.tag,
                                 model_mant(e.sum), model_shift(e.sum));
                    end
                    recv++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_mant  = out_mant;
            prev_tag   = out_tag;
        end
        checks++; if (recv != 8) begin errors++;
            $display("FAIL b2b_count: got %0d want 8", recv); end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_flight();
        @(posedge clk); #1;
        in_valid = 1'b1; in_sum = 17'h00400; in_tag = 8'hE1;
        @(posedge clk); #1;
        in_sum = 17'h00020; in_tag = 8'hE2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++;
            $display("FAIL mid_inflight: got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        checks++; if (out_mant !== '0 || out_shift !== '0 || out_tag !== '0) begin errors++;
            $display("FAIL mid_rst_data: got m=%h s=%0d t=%h want 0", out_mant, out_shift,
                     out_tag); end
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++;
                $display("FAIL mid_no_stale[%0d]: got %b want 0", i, out_valid); end
        end
        push_single(17'h00800, 8'hE7);
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL mid_latency: out_valid %b want 0 one cycle in", out_valid); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_mant !== 17'h10000 || out_shift !== 5'd5 ||
            out_tag !== 8'hE7) begin
            errors++;
            $display("FAIL mid_new_item: got v=%b m=%h s=%0d t=%h want v=1 m=10000 s=5 t=e7",
                     out_valid, out_mant, out_shift, out_tag);
        end
    endtask

    task automatic test_random();
        int unsigned      sent, recv, cyc, exp_sh;
        logic             hold, prev_stall;
        logic [SUM_W-1:0] prev_mant, exp_m;
        logic [TAG_W-1:0] prev_tag;
        shift_t           prev_shift;
        item_t            it, e;
        sent = 0; recv = 0; cyc = 0; hold = 1'b0; prev_stall = 1'b0;
        prev_mant = '0; prev_tag = '0; prev_shift = '0;
        exp_q.delete();
        @(posedge clk);
        while (recv < N_RAND && cyc < BUDGET) begin
            @(posedge clk); #1;
            if (!hold) begin
                if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_sum   = 17'($urandom) >> $urandom_range(0, 17);
                    in_tag   = 8'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_mant !== prev_mant || out_tag !== prev_tag ||
                    out_shift !== prev_shift) begin
                    errors++;
                    $display("FAIL rand_hold[%0d]: got v=%b m=%h s=%0d t=%h want v=1 m=%h s=%0d t=%h",
                             cyc, out_valid, out_mant, out_shift, out_tag, prev_mant,
                             prev_shift, prev_tag);
                end
            end
            hold = in_valid && !in_ready;
            if (in_valid && in_ready) begin
                it.sum = in_sum; it.tag = in_tag;
                exp_q.push_back(it);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got tag %h want no output", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    exp_sh = lzc_sat(32'(e.sum), MAX_SHIFT, SUM_W);
                    exp_m  = e.sum << exp_sh;
`ifdef FPADD_NORM_ZERO_EN
                    if (e.sum == '0) exp_sh = 0;
                    if (out_zero !== (e.sum == '0)) begin
                        errors++;
                        $display("FAIL rand_zero[%0d]: got %b want %b", recv, out_zero,
                                 (e.sum == '0));
                    end
`endif
                    if (out_tag !== e.tag || out_mant !== exp_m || out_shift !== 5'(exp_sh)) begin
                        errors++;
                        $display("FAIL rand_item[%0d]: got t=%h m=%h s=%0d want t=%h m=%h s=%0d",
                                 recv, out_tag, out_mant, out_shift, e.tag, exp_m, exp_sh);
                    end
                    recv++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_mant  = out_mant;
            prev_shift = out_shift;
            prev_tag   = out_tag;
            cyc++;
        end
        checks++; if (recv != N_RAND) begin errors++;
            $display("FAIL rand_count: got %0d want %0d within %0d cycles", recv, N_RAND, BUDGET);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        test_reset();
        test_normalise();
        test_saturation();
        test_back_to_back();
        test_reset_mid_flight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
